// File: rtl/fifo_ser_pkg.sv
// fifo_ser_pkg: shared defaults and types for the FIFO word serializer.
//   WORD_WIDTH / WORDS : default word width and words per entry
//   ENTRY_WIDTH        : width of one upstream entry
//   IDX_WIDTH          : width of the word index for the defaults
//   word_t / entry_t   : word and entry types at the default sizes
//   idx_width()        : index width for an arbitrary word count
package fifo_ser_pkg;

  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned WORDS       = 3;
  localparam int unsigned ENTRY_WIDTH = WORD_WIDTH * WORDS;
  localparam int unsigned IDX_WIDTH   = $clog2(WORDS);

  typedef logic [WORD_WIDTH-1:0]  word_t;
  typedef logic [ENTRY_WIDTH-1:0] entry_t;

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/fifo_ser_word_mux.sv
// fifo_ser_word_mux: combinational select of one word out of an entry.
//   entry : WORD_WIDTH*WORDS-bit entry, word 0 in the low bits
//   idx   : word index, 0..WORDS-1
//   word  : selected word (zero for index codes beyond WORDS-1)
module fifo_ser_word_mux #(
  parameter int unsigned WORD_WIDTH = fifo_ser_pkg::WORD_WIDTH,
  parameter int unsigned WORDS      = fifo_ser_pkg::WORDS
) (
  input  logic [WORD_WIDTH*WORDS-1:0]                  entry,
  input  logic [fifo_ser_pkg::idx_width(WORDS)-1:0]    idx,
  output logic [WORD_WIDTH-1:0]                        word
);
  import fifo_ser_pkg::*;

  localparam int unsigned IDX_W = idx_width(WORDS);

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx == IDX_W'(i)) word = entry[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

endmodule

// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: drains WORD_WIDTH*WORDS-bit entries from a first/deq
// FIFO interface and emits them low word first on an enq-style interface.
//   CLK, nRST      : clock, asynchronous active-low reset
//   in_first       : head entry of the upstream FIFO
//   in_first__RDY  : head entry valid
//   in_deq__RDY    : upstream can dequeue
//   in_deq__ENA    : dequeue the head entry this cycle
//   out_enq__ENA   : a word is transferred this cycle
//   out_enq_v      : current word
//   out_enq__RDY   : downstream can accept a word
// Optional (FIFO_WORD_SERIALIZER_LAST_EN defined):
//   out_enq_last   : current word is the last of its entry
//   entry_count    : 16-bit wrapping count of fully sent entries
module fifo_word_serializer #(
  parameter int unsigned WORD_WIDTH = fifo_ser_pkg::WORD_WIDTH,
  parameter int unsigned WORDS      = fifo_ser_pkg::WORDS
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [WORD_WIDTH*WORDS-1:0]   in_first,
  input  logic                          in_first__RDY,
  input  logic                          in_deq__RDY,
  output logic                          in_deq__ENA,
  output logic                          out_enq__ENA,
  output logic [WORD_WIDTH-1:0]         out_enq_v,
`ifdef FIFO_WORD_SERIALIZER_LAST_EN
  output logic                          out_enq_last,
  output logic [15:0]                   entry_count,
`endif
  input  logic                          out_enq__RDY
);
  import fifo_ser_pkg::*;

  localparam int unsigned IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [WORD_WIDTH*WORDS-1:0] hold;
  logic                        valid;
  logic [IDX_W-1:0]            idx;

  logic enq_ena;
  logic at_last;
  logic last_xfer;
  logic load;

  always_comb begin
    enq_ena   = valid & out_enq__RDY;
    at_last   = (idx == LAST_IDX);
    last_xfer = enq_ena & at_last;
    // nRST gating keeps the deq strobe low while reset is held.
    load      = nRST & in_first__RDY & in_deq__RDY & (~valid | last_xfer);
  end

  assign in_deq__ENA  = load;
  assign out_enq__ENA = enq_ena;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hold  <= '0;
      valid <= 1'b0;
      idx   <= '0;
    end else if (load) begin
      // Also covers the final word going out in the same cycle: no bubble.
      hold  <= in_first;
      valid <= 1'b1;
      idx   <= '0;
    end else if (last_xfer) begin
      valid <= 1'b0;
      idx   <= '0;
    end else if (enq_ena) begin
      idx   <= idx + IDX_W'(1);
    end
  end

  fifo_ser_word_mux #(
    .WORD_WIDTH (WORD_WIDTH),
    .WORDS      (WORDS)
  ) u_word_mux (
    .entry (hold),
    .idx   (idx),
    .word  (out_enq_v)
  );

`ifdef FIFO_WORD_SERIALIZER_LAST_EN
  assign out_enq_last = valid & at_last;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      entry_count <= '0;
    end else if (last_xfer) begin
      entry_count <= entry_count + 16'd1;
    end
  end
`endif

endmodule
